wave_ctrl_mc: RTL and testbench
===============================

# wave_ctrl_mc

Multi-channel configuration controller for the waveform generator. After reset, or on request, it walks a header table in waveform BRAM and fetches a frequency divisor and a sample count for each of NUM_CH channels. It validates each header, then releases every valid channel's freq_divisor and bram_reader out of reset on the same clock edge so all channels start phase-aligned. It replaces the single-channel Ctrl and adds parametrised channel count and BRAM latency, header validation, a sample base-address output and run-time reload.

## Interface
- DATA_W, 32, BRAM word width and width of each divisor/sample-count field
- ADDR_W, 32, BRAM word-address width
- NUM_CH, 2, number of channels (1..8)
- HDR_STRIDE, 4, words between consecutive channel headers (≥2)
- RD_LAT, 1, BRAM read latency in cycles (1..4)
- MIN_DIV, 2, smallest legal divisor
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- reload  in  1  single-cycle request to re-fetch all headers; honoured only in RUN
- bram_read  in  DATA_W  BRAM read data
- bram_addr  out  ADDR_W  BRAM word address, registered
- bram_en  out  1  BRAM read enable, high only in FETCH_DIV/FETCH_N
- freq_divisor_rstn  out  NUM_CH  per-channel active-low reset for the frequency divisor
- bram_reader_rstn  out  NUM_CH  per-channel active-low reset for the sample reader
- freq_divisor_value  out  NUM_CH*DATA_W  channel c at bits [c*DATA_W +: DATA_W]
- num_of_samples  out  NUM_CH*DATA_W  same packing
- ch_base  out  NUM_CH*ADDR_W  first sample word address of channel c, which is c*HDR_STRIDE+2
- cfg_err  out  NUM_CH  header of channel c rejected
- busy  out  1  high from IDLE exit until RUN entry
- cfg_done  out  1  one-cycle pulse on the edge entering RUN

## Operation
- Header layout for channel c: word c*HDR_STRIDE+0 holds the divisor, +1 holds the sample count, and samples start at +2.
- FSM states: IDLE → FETCH_DIV → WAIT_DIV → FETCH_N → WAIT_N → COMMIT → (next channel: FETCH_DIV | last channel: RUN); RUN → FETCH_DIV (channel 0) on reload.
- IDLE is the reset state. It exits unconditionally on the first clock after reset deasserts.
- FETCH_*: bram_addr holds the header word address and bram_en=1, for 1 cycle.
- WAIT_*: lasts RD_LAT cycles. bram_read is captured on the edge that ends the last WAIT cycle.
- COMMIT (1 cycle):
  - Write divisor, sample count and ch_base into channel c's registers.
  - Set cfg_err[c]=1 if divisor < MIN_DIV or sample count == 0.
  - Advance the channel counter.
- RUN entry (edge COMMIT→RUN):
  - For each c with cfg_err[c]=0, set freq_divisor_rstn[c] and bram_reader_rstn[c] to 1.
  - Erroneous channels stay held in reset.
  - cfg_done pulses and busy falls.
- Reload in RUN: on the next edge, all rstn bits go 0, all cfg_err bits clear, busy goes 1, and the FSM enters FETCH_DIV for channel 0. Value outputs hold their old contents until overwritten in COMMIT.
- reload outside RUN is ignored; there is no queueing.
- Comparisons are unsigned at DATA_W. ch_base is computed at ADDR_W and wraps modulo 2^ADDR_W.

## Timing
- Reset values:
  - All value outputs are 0, bram_addr=0, bram_en=0.
  - All rstn bits are 0, cfg_err=0, busy=0, cfg_done=0.
- Per-channel fetch cost is 2*(1+RD_LAT)+1 cycles.
- Reset deassert to cfg_done: 1 + NUM_CH*(2*RD_LAT+3) cycles. With the defaults this is 11 cycles.
- Reload sample edge to cfg_done: NUM_CH*(2*RD_LAT+3) cycles.
- All rstn rising edges for valid channels occur on the same clock edge.
- Asserting reset at any point, including mid-fetch, asynchronously returns every output to its reset value and the FSM to IDLE. The partially fetched header is discarded.
- bram_read is sampled only at the capture edges. It is don't-care at all other times.

## Structure
- Package wave_pkg holds:
  - the FSM state enum;
  - header offset constants HDR_DIV_OFS=0, HDR_NS_OFS=1, HDR_DATA_OFS=2;
  - a helper function for the header word address (ch, stride, ofs).
- One sub-module, wave_ch_cfg: a per-channel register slice holding divisor, sample count, base and err. It has a commit strobe and a release strobe, and is instantiated NUM_CH times by generate.
- The top level contains the FSM, the channel counter, the RD_LAT wait counter and output packing.

## Test plan
- Defaults; header ch0 = {1250, 100}, ch1 = {500, 64}:
  - bram_addr sequence is 0,1,4,5.
  - cfg_done arrives 11 cycles after reset deasserts.
  - Outputs are div=1250/500, ns=100/64, ch_base=2/6.
  - Both rstn pairs rise on the same edge.
- ch1 divisor = 1 → cfg_err=2'b10, channel 1 rstn stays 0, channel 0 released normally. Repeat with ch0 sample count = 0 → cfg_err=2'b01.
- RD_LAT=3, NUM_CH=4, HDR_STRIDE=8:
  - Captures occur exactly 3 cycles after each bram_en pulse.
  - Addresses are 0,1,8,9,16,17,24,25.
  - cfg_done arrives 1+4*9=37 cycles after reset.
- In RUN, change ch0 header to {2000, 50} and pulse reload:
  - rstn drops next cycle.
  - cfg_done arrives 10 cycles after the reload edge with new values.
- Reload pulsed during a fetch → ignored. Reset asserted in WAIT_N of ch1 → all outputs return to 0 asynchronously and the fetch restarts cleanly from channel 0.

Source files
------------

// File: rtl/wave_pkg.sv
// Shared types and header-layout helpers for the multi-channel waveform controller.
package wave_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_DIV,
    WAIT_DIV,
    FETCH_N,
    WAIT_N,
    COMMIT,
    RUN
  } state_e;

  localparam int unsigned HDR_DIV_OFS  = 0;
  localparam int unsigned HDR_NS_OFS   = 1;
  localparam int unsigned HDR_DATA_OFS = 2;

  // Callers truncate the result to their address width, so the address wraps there.
  function automatic logic [63:0] hdr_word_addr(input logic [31:0] ch,
                                                input logic [31:0] stride,
                                                input logic [31:0] ofs);
    return 64'(ch) * 64'(stride) + 64'(ofs);
  endfunction

endpackage

// File: rtl/wave_ch_cfg.sv
// Per-channel configuration slice: divisor, sample count, base address, error flag
// and the two active-low channel resets.
module wave_ch_cfg #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned MIN_DIV = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_commit,
  input  logic              i_release,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_div,
  input  logic [DATA_W-1:0] i_ns,
  input  logic [ADDR_W-1:0] i_base,
  output logic [DATA_W-1:0] o_div,
  output logic [DATA_W-1:0] o_ns,
  output logic [ADDR_W-1:0] o_base,
  output logic              o_err,
  output logic              o_fd_rstn,
  output logic              o_br_rstn
);

  logic [DATA_W-1:0] r_div;
  logic [DATA_W-1:0] r_ns;
  logic [ADDR_W-1:0] r_base;
  logic              r_err;
  logic              r_fd_rstn;
  logic              r_br_rstn;
  logic              w_bad;
  logic              w_err_next;

  assign w_bad      = (i_div < DATA_W'(MIN_DIV)) || (i_ns == '0);
  // The last channel commits on the same edge as the release, so release uses the fresh verdict.
  assign w_err_next = i_commit ? w_bad : r_err;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div     <= '0;
      r_ns      <= '0;
      r_base    <= '0;
      r_err     <= 1'b0;
      r_fd_rstn <= 1'b0;
      r_br_rstn <= 1'b0;
    end else begin
      if (i_commit) begin
        r_div  <= i_div;
        r_ns   <= i_ns;
        r_base <= i_base;
      end
      if (i_clear) begin
        r_err     <= 1'b0;
        r_fd_rstn <= 1'b0;
        r_br_rstn <= 1'b0;
      end else begin
        r_err <= w_err_next;
        if (i_release) begin
          r_fd_rstn <= ~w_err_next;
          r_br_rstn <= ~w_err_next;
        end
      end
    end
  end

  assign o_div     = r_div;
  assign o_ns      = r_ns;
  assign o_base    = r_base;
  assign o_err     = r_err;
  assign o_fd_rstn = r_fd_rstn;
  assign o_br_rstn = r_br_rstn;

endmodule

// File: rtl/wave_ctrl_mc.sv
// Multi-channel waveform configuration controller: walks the BRAM header table,
// validates each channel and releases all valid channels on one common edge.
module wave_ctrl_mc
  import wave_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned HDR_STRIDE = 4,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned MIN_DIV    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     reload,
  input  logic [DATA_W-1:0]        bram_read,
  output logic [ADDR_W-1:0]        bram_addr,
  output logic                     bram_en,
  output logic [NUM_CH-1:0]        freq_divisor_rstn,
  output logic [NUM_CH-1:0]        bram_reader_rstn,
  output logic [NUM_CH*DATA_W-1:0] freq_divisor_value,
  output logic [NUM_CH*DATA_W-1:0] num_of_samples,
  output logic [NUM_CH*ADDR_W-1:0] ch_base,
  output logic [NUM_CH-1:0]        cfg_err,
  output logic                     busy,
  output logic                     cfg_done
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [CH_W-1:0] ch,
                                                 input int unsigned ofs);
    return ADDR_W'(hdr_word_addr(32'(ch), 32'(HDR_STRIDE), 32'(ofs)));
  endfunction

  state_e            r_state;
  logic [CH_W-1:0]   r_ch;
  logic [2:0]        r_wait;
  logic [DATA_W-1:0] r_div;
  logic [DATA_W-1:0] r_ns;
  logic [ADDR_W-1:0] r_addr;
  logic              r_en;
  logic              r_busy;
  logic              r_done;

  logic              w_last;
  logic [CH_W-1:0]   w_ch_next;
  logic [ADDR_W-1:0] w_base;
  logic [NUM_CH-1:0] w_commit;
  logic              w_release;
  logic              w_clear;

  assign w_last    = (r_ch == CH_W'(NUM_CH - 1));
  assign w_ch_next = r_ch + 1'b1;
  assign w_base    = addr_of(r_ch, HDR_DATA_OFS);
  assign w_release = (r_state == COMMIT) && w_last;
  assign w_clear   = (r_state == RUN) && reload;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_ch    <= '0;
      r_wait  <= '0;
      r_div   <= '0;
      r_ns    <= '0;
      r_addr  <= '0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_state <= FETCH_DIV;
          r_ch    <= '0;
          r_addr  <= addr_of('0, HDR_DIV_OFS);
          r_en    <= 1'b1;
          r_busy  <= 1'b1;
        end
        FETCH_DIV: begin
          r_state <= WAIT_DIV;
          r_en    <= 1'b0;
          r_wait  <= 3'(RD_LAT - 1);
        end
        WAIT_DIV: begin
          if (r_wait == '0) begin
            r_div   <= bram_read;
            r_state <= FETCH_N;
            r_addr  <= addr_of(r_ch, HDR_NS_OFS);
            r_en    <= 1'b1;
          end else begin
            r_wait <= r_wait - 1'b1;
          end
        end
        FETCH_N: begin
          r_state <= WAIT_N;
          r_en    <= 1'b0;
          r_wait  <= 3'(RD_LAT - 1);
        end
        WAIT_N: begin
          if (r_wait == '0) begin
            r_ns    <= bram_read;
            r_state <= COMMIT;
          end else begin
            r_wait <= r_wait - 1'b1;
          end
        end
        COMMIT: begin
          if (w_last) begin
            r_state <= RUN;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_ch    <= w_ch_next;
            r_state <= FETCH_DIV;
            r_addr  <= addr_of(w_ch_next, HDR_DIV_OFS);
            r_en    <= 1'b1;
          end
        end
        RUN: begin
          // Reload is only sampled here; requests during a fetch are dropped.
          if (reload) begin
            r_state <= FETCH_DIV;
            r_ch    <= '0;
            r_addr  <= addr_of('0, HDR_DIV_OFS);
            r_en    <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign w_commit[c] = (r_state == COMMIT) && (r_ch == CH_W'(c));

    wave_ch_cfg #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .MIN_DIV (MIN_DIV)
    ) u_cfg (
      .clk       (clk),
      .reset     (reset),
      .i_commit  (w_commit[c]),
      .i_release (w_release),
      .i_clear   (w_clear),
      .i_div     (r_div),
      .i_ns      (r_ns),
      .i_base    (w_base),
      .o_div     (freq_divisor_value[c*DATA_W +: DATA_W]),
      .o_ns      (num_of_samples[c*DATA_W +: DATA_W]),
      .o_base    (ch_base[c*ADDR_W +: ADDR_W]),
      .o_err     (cfg_err[c]),
      .o_fd_rstn (freq_divisor_rstn[c]),
      .o_br_rstn (bram_reader_rstn[c])
    );
  end

  assign bram_addr = r_addr;
  assign bram_en   = r_en;
  assign busy      = r_busy;
  assign cfg_done  = r_done;

endmodule

// File: tb/tb_wave_ctrl_mc.sv
// Scoreboard bench: two controller instances (defaults, and 4 channels / latency 3 / stride 8)
// each fed by a BRAM model; monitors compare fetch addresses and cfg_done results.
module tb_wave_ctrl_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    int           cyc;
    logic [127:0] div;
    logic [127:0] ns;
    logic [127:0] base;
    logic [3:0]   err;
    logic [3:0]   rstn;
  } exp_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
    n_total++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic fail_now(input string name);
    n_total++;
    n_bad++;
    $display("FAIL %s", name);
  endtask

  task automatic check_done(input string tag, input exp_t e, input int dcyc,
                            input logic [127:0] div, input logic [127:0] ns,
                            input logic [127:0] base, input logic [3:0] err,
                            input logic [3:0] fdr, input logic [3:0] brr,
                            input logic bsy, input logic [3:0] prev);
    check({tag, "_latency"}, dcyc, e.cyc);
    check({tag, "_div"}, div, e.div);
    check({tag, "_ns"}, ns, e.ns);
    check({tag, "_base"}, base, e.base);
    check({tag, "_err"}, err, e.err);
    check({tag, "_fd_rstn"}, fdr, e.rstn);
    check({tag, "_br_rstn"}, brr, e.rstn);
    check({tag, "_busy_low"}, bsy, 1'b0);
    check({tag, "_rstn_before_done"}, prev, 4'b0);
  endtask

  // ---------------- instance 0: default parameters ----------------
  logic         rst0 = 1'b1;
  logic         reload0 = 1'b0;
  logic [31:0]  rd0;
  logic [31:0]  addr0;
  logic         en0;
  logic [1:0]   fdr0, brr0, err0;
  logic [63:0]  div0, ns0, base0;
  logic         busy0, done0;
  logic [31:0]  mem0 [0:63];

  wave_ctrl_mc dut0 (
    .clk(clk), .reset(rst0), .reload(reload0), .bram_read(rd0),
    .bram_addr(addr0), .bram_en(en0),
    .freq_divisor_rstn(fdr0), .bram_reader_rstn(brr0),
    .freq_divisor_value(div0), .num_of_samples(ns0), .ch_base(base0),
    .cfg_err(err0), .busy(busy0), .cfg_done(done0)
  );

  always @(posedge clk) rd0 <= en0 ? mem0[addr0[5:0]] : 32'hDEAD_BEEF;

  // ---------------- instance 4: 4 channels, latency 3, stride 8 ----------------
  logic         rst4 = 1'b1;
  logic         reload4 = 1'b0;
  logic [31:0]  rd4;
  logic [31:0]  addr4;
  logic         en4;
  logic [3:0]   fdr4, brr4, err4;
  logic [127:0] div4, ns4, base4;
  logic         busy4, done4;
  logic [31:0]  mem4 [0:63];
  logic [31:0]  pipe4 [0:2];

  wave_ctrl_mc #(.NUM_CH(4), .RD_LAT(3), .HDR_STRIDE(8)) dut4 (
    .clk(clk), .reset(rst4), .reload(reload4), .bram_read(rd4),
    .bram_addr(addr4), .bram_en(en4),
    .freq_divisor_rstn(fdr4), .bram_reader_rstn(brr4),
    .freq_divisor_value(div4), .num_of_samples(ns4), .ch_base(base4),
    .cfg_err(err4), .busy(busy4), .cfg_done(done4)
  );

  always @(posedge clk) begin
    pipe4[0] <= en4 ? mem4[addr4[5:0]] : 32'hDEAD_BEEF;
    pipe4[1] <= pipe4[0];
    pipe4[2] <= pipe4[1];
  end
  assign rd4 = pipe4[2];

  // ---------------- scoreboards and monitors ----------------
  logic [31:0] q_addr0[$];
  logic [31:0] q_addr4[$];
  exp_t        q_done0[$];
  exp_t        q_done4[$];
  int          start0 = 0;
  int          start4 = 0;
  logic [3:0]  prev0 = '0;
  logic [3:0]  prev4 = '0;

  always @(negedge clk) begin
    if (!rst0) begin
      if (en0) begin
        if (q_addr0.size() == 0) fail_now("dut0_extra_fetch");
        else begin
          check("dut0_addr", addr0, q_addr0.pop_front());
          check("dut0_busy_fetch", busy0, 1'b1);
        end
      end
      if (done0) begin
        if (q_done0.size() == 0) fail_now("dut0_extra_done");
        else check_done("dut0", q_done0.pop_front(), cyc - start0, div0, ns0, base0,
                        err0, fdr0, brr0, busy0, prev0);
      end
    end
    prev0 <= {2'b00, fdr0 | brr0};
  end

  always @(negedge clk) begin
    if (!rst4) begin
      if (en4) begin
        if (q_addr4.size() == 0) fail_now("dut4_extra_fetch");
        else check("dut4_addr", addr4, q_addr4.pop_front());
      end
      if (done4) begin
        if (q_done4.size() == 0) fail_now("dut4_extra_done");
        else check_done("dut4", q_done4.pop_front(), cyc - start4, div4, ns4, base4,
                        err4, fdr4, brr4, busy4, prev4);
      end
    end
    prev4 <= fdr4 | brr4;
  end

  // ---------------- stimulus helpers ----------------
  function automatic bit pending(input int which);
    if (which == 0) return (q_addr0.size() + q_done0.size()) != 0;
    return (q_addr4.size() + q_done4.size()) != 0;
  endfunction

  task automatic drain(input int which, input int budget);
    int n = 0;
    while (n < budget && pending(which)) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (pending(which)) fail_now(which == 0 ? "dut0_timeout" : "dut4_timeout");
  endtask

  task automatic push_fetch0();
    q_addr0.push_back(32'd0);
    q_addr0.push_back(32'd1);
    q_addr0.push_back(32'd4);
    q_addr0.push_back(32'd5);
  endtask

  task automatic exp_done0(input int cy, input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] n0, input logic [31:0] n1, input logic [1:0] err);
    exp_t e;
    e.cyc  = cy;
    e.div  = {64'd0, d1, d0};
    e.ns   = {64'd0, n1, n0};
    e.base = {64'd0, 32'd6, 32'd2};
    e.err  = {2'b00, err};
    e.rstn = {2'b00, ~err};
    q_done0.push_back(e);
  endtask

  task automatic pulse_reload0();
    @(negedge clk);
    reload0 = 1'b1;
    start0  = cyc + 1;
    @(negedge clk);
    reload0 = 1'b0;
  endtask

  task automatic check_reset0(input string tag);
    check({tag, "_addr"}, addr0, 32'd0);
    check({tag, "_en"}, en0, 1'b0);
    check({tag, "_fd_rstn"}, fdr0, 2'b00);
    check({tag, "_br_rstn"}, brr0, 2'b00);
    check({tag, "_div"}, div0, 64'd0);
    check({tag, "_ns"}, ns0, 64'd0);
    check({tag, "_base"}, base0, 64'd0);
    check({tag, "_err"}, err0, 2'b00);
    check({tag, "_busy"}, busy0, 1'b0);
    check({tag, "_done"}, done0, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    exp_t e4;
    for (int i = 0; i < 64; i++) begin
      mem0[i] = 32'd0;
      mem4[i] = 32'd0;
    end
    mem0[0] = 32'd1250; mem0[1] = 32'd100; mem0[4] = 32'd500; mem0[5] = 32'd64;
    mem4[0]  = 32'd10;  mem4[1]  = 32'd1;
    mem4[8]  = 32'd2;   mem4[9]  = 32'd5;
    mem4[16] = 32'd1;   mem4[17] = 32'd9;
    mem4[24] = 32'd300; mem4[25] = 32'd0;

    repeat (3) @(negedge clk);
    check_reset0("rst0");

    // Power-up fetch with default headers
    push_fetch0();
    exp_done0(11, 32'd1250, 32'd500, 32'd100, 32'd64, 2'b00);
    rst0   = 1'b0;
    start0 = cyc;
    drain(0, 40);

    // Reload with a new channel-0 header
    mem0[0] = 32'd2000; mem0[1] = 32'd50;
    push_fetch0();
    exp_done0(10, 32'd2000, 32'd500, 32'd50, 32'd64, 2'b00);
    pulse_reload0();
    check("reload_fd_rstn_drop", fdr0, 2'b00);
    check("reload_br_rstn_drop", brr0, 2'b00);
    check("reload_busy", busy0, 1'b1);
    check("reload_div_held", div0, {32'd500, 32'd1250});
    drain(0, 40);

    // Channel 1 divisor below the minimum
    mem0[4] = 32'd1;
    push_fetch0();
    exp_done0(10, 32'd2000, 32'd1, 32'd50, 32'd64, 2'b10);
    pulse_reload0();
    drain(0, 40);

    // Channel 0 sample count zero; channel 1 divisor exactly at the minimum
    mem0[4] = 32'd2; mem0[1] = 32'd0;
    push_fetch0();
    exp_done0(10, 32'd2000, 32'd2, 32'd0, 32'd64, 2'b01);
    pulse_reload0();
    check("reload_clears_err", err0, 2'b00);
    drain(0, 40);

    // Reload pulsed mid-fetch must be ignored
    mem0[0] = 32'd1250; mem0[1] = 32'd100;
    push_fetch0();
    exp_done0(10, 32'd1250, 32'd2, 32'd100, 32'd64, 2'b00);
    pulse_reload0();
    repeat (2) @(negedge clk);
    reload0 = 1'b1;
    @(negedge clk);
    reload0 = 1'b0;
    drain(0, 40);

    // Asynchronous reset while in WAIT_N of channel 1
    mem0[4] = 32'd500;
    push_fetch0();
    pulse_reload0();
    repeat (8) @(posedge clk);
    #2;
    rst0 = 1'b1;
    #1;
    check_reset0("midrst");
    check("midrst_fetches_seen", q_addr0.size(), 0);
    mem0[4] = 32'd700; mem0[5] = 32'd7;
    repeat (2) @(negedge clk);
    push_fetch0();
    exp_done0(11, 32'd1250, 32'd700, 32'd100, 32'd7, 2'b00);
    rst0   = 1'b0;
    start0 = cyc;
    drain(0, 40);

    // Four channels, read latency 3, stride 8
    check("dut4_rst_addr", addr4, 32'd0);
    check("dut4_rst_rstn", fdr4, 4'b0000);
    check("dut4_rst_div", div4, 128'd0);
    for (int c = 0; c < 4; c++) begin
      q_addr4.push_back(32'(8 * c));
      q_addr4.push_back(32'(8 * c + 1));
    end
    e4.cyc  = 37;
    e4.div  = {32'd300, 32'd1, 32'd2, 32'd10};
    e4.ns   = {32'd0, 32'd9, 32'd5, 32'd1};
    e4.base = {32'd26, 32'd18, 32'd10, 32'd2};
    e4.err  = 4'b1100;
    e4.rstn = 4'b0011;
    q_done4.push_back(e4);
    @(negedge clk);
    rst4   = 1'b0;
    start4 = cyc;
    drain(4, 80);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
